// File: rtl/schedule_table_sequencer.sv
// Steps through a register-held schedule table and hands each entry to the
// window checker one LEAD ahead of its absolute start, skipping expired entries.
module schedule_table_sequencer #(
  parameter int DEPTH = 8,
  parameter int LEAD  = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_port,
  input  logic [15:0] cfg_buffer,
  input  logic [63:0] cfg_start,
  input  logic [63:0] cfg_end,
  input  logic [15:0] cfg_flow,
  input  logic [3:0]  cfg_num,
  input  logic [63:0] cfg_period,
  input  logic        cfg_enable,
  input  logic [63:0] in_global_time,
  input  logic        in_table_rdy,
  output logic        out_table_wr,
  output logic [15:0] out_port_number,
  output logic [15:0] out_buffer_number,
  output logic [63:0] out_window_start,
  output logic [63:0] out_window_end,
  output logic [15:0] out_flow_id,
  output logic        out_busy,
  output logic [2:0]  out_entry_idx,
  output logic [15:0] out_miss_cnt
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RDY, WAIT_LEAD, ISSUE, GUARD} state_t;

  localparam logic [3:0]  DEPTH_N = 4'(DEPTH);
  localparam logic [63:0] LEAD_T  = 64'(LEAD);

  state_t state, next_state;

  logic [15:0] tbl_port   [DEPTH];
  logic [15:0] tbl_buffer [DEPTH];
  logic [15:0] tbl_flow   [DEPTH];
  logic [63:0] tbl_start  [DEPTH];
  logic [63:0] tbl_end    [DEPTH];

  logic [63:0] base, base_adv, abs_start, abs_end;
  logic [3:0]  num_l, num_clamped;
  logic [2:0]  idx, idx_adv;
  logic [15:0] miss_cnt;
  logic        expired, lead_ok, last_entry;

  assign num_clamped = (cfg_num > DEPTH_N) ? DEPTH_N : cfg_num;
  assign expired     = in_global_time > abs_end;
  assign lead_ok     = (in_global_time + LEAD_T) >= abs_start;

  // Finishing the last entry rolls the schedule into the next period.
  assign last_entry  = ({1'b0, idx} + 4'd1) >= num_l;
  assign idx_adv     = last_entry ? 3'd0 : idx + 3'd1;
  assign base_adv    = last_entry ? base + cfg_period : base;

  assign out_entry_idx = idx;
  assign out_miss_cnt  = miss_cnt;

  always_ff @(posedge clk) begin
    if (cfg_wr && state == IDLE) begin
      tbl_port[cfg_addr]   <= cfg_port;
      tbl_buffer[cfg_addr] <= cfg_buffer;
      tbl_flow[cfg_addr]   <= cfg_flow;
      tbl_start[cfg_addr]  <= cfg_start;
      tbl_end[cfg_addr]    <= cfg_end;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Dropping cfg_enable overrides every transition, including a pending issue.
  always_comb begin
    next_state = state;
    if (!cfg_enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:      if (cfg_num != 4'd0) next_state = FETCH;
        FETCH:     next_state = WAIT_RDY;
        WAIT_RDY:  if (in_table_rdy) next_state = WAIT_LEAD;
        WAIT_LEAD: begin
          if (expired) begin
            next_state = FETCH;
          end else if (lead_ok) begin
            next_state = ISSUE;
          end
        end
        ISSUE:     next_state = GUARD;
        GUARD:     next_state = FETCH;
        default:   next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    out_table_wr = (state == ISSUE);
    out_busy     = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base              <= '0;
      abs_start         <= '0;
      abs_end           <= '0;
      num_l             <= '0;
      idx               <= '0;
      miss_cnt          <= '0;
      out_port_number   <= '0;
      out_buffer_number <= '0;
      out_window_start  <= '0;
      out_window_end    <= '0;
      out_flow_id       <= '0;
    end else if (cfg_enable) begin
      case (state)
        IDLE: begin
          if (cfg_num != 4'd0) begin
            base  <= in_global_time;
            num_l <= num_clamped;
            idx   <= '0;
          end
        end
        FETCH: begin
          abs_start <= base + tbl_start[idx];
          abs_end   <= base + tbl_end[idx];
        end
        WAIT_LEAD: begin
          if (expired) begin
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            idx  <= idx_adv;
            base <= base_adv;
          end else if (lead_ok) begin
            out_port_number   <= tbl_port[idx];
            out_buffer_number <= tbl_buffer[idx];
            out_flow_id       <= tbl_flow[idx];
            out_window_start  <= abs_start;
            out_window_end    <= abs_end;
          end
        end
        ISSUE: begin
          idx  <= idx_adv;
          base <= base_adv;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_schedule_table_sequencer.sv
// Bench for schedule_table_sequencer: an entry-by-entry timing model predicts
// every output on every cycle for directed and randomized segments.
module tb_schedule_table_sequencer;

  localparam int LEAD = 200;
  localparam int MAXC = 1024;

  logic        clk = 1'b0;
  logic        rst_n, cfg_wr, cfg_enable, in_table_rdy;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_port, cfg_buffer, cfg_flow;
  logic [63:0] cfg_start, cfg_end, cfg_period, in_global_time;
  logic [3:0]  cfg_num;
  logic        out_table_wr, out_busy;
  logic [15:0] out_port_number, out_buffer_number, out_flow_id, out_miss_cnt;
  logic [63:0] out_window_start, out_window_end;
  logic [2:0]  out_entry_idx;

  always #5 clk = ~clk;

  schedule_table_sequencer #(.DEPTH(8), .LEAD(LEAD)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_port(cfg_port), .cfg_buffer(cfg_buffer), .cfg_start(cfg_start),
    .cfg_end(cfg_end), .cfg_flow(cfg_flow), .cfg_num(cfg_num),
    .cfg_period(cfg_period), .cfg_enable(cfg_enable),
    .in_global_time(in_global_time), .in_table_rdy(in_table_rdy),
    .out_table_wr(out_table_wr), .out_port_number(out_port_number),
    .out_buffer_number(out_buffer_number), .out_window_start(out_window_start),
    .out_window_end(out_window_end), .out_flow_id(out_flow_id),
    .out_busy(out_busy), .out_entry_idx(out_entry_idx), .out_miss_cnt(out_miss_cnt)
  );

  typedef struct packed {
    logic        wr;
    logic        busy;
    logic [2:0]  idx;
    logic [15:0] miss, port, bufn, flow;
    logic [63:0] ws, we;
  } exp_t;

  int n_cmp = 0, n_bad = 0, cyc = -1, seg_len = 0;

  logic [15:0] m_port [8], m_buf [8], m_flow [8];
  logic [63:0] m_start [8], m_end [8];
  logic [15:0] h_port, h_buf, h_flow, h_miss;
  logic [63:0] h_ws, h_we;
  logic [2:0]  h_idx;

  logic [63:0] s_gt [MAXC];
  bit          s_rdy [MAXC], s_en [MAXC];
  logic [3:0]  s_num;
  logic [63:0] s_period;
  exp_t        exp_a [MAXC];

  logic [15:0] w_port, w_buf, w_flow;
  logic [63:0] w_start, w_end;

  task automatic check_field(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, req);
    end
  endtask

  task automatic check_output(input exp_t e);
    check_field("table_wr",   64'(out_table_wr),      64'(e.wr));
    check_field("busy",       64'(out_busy),          64'(e.busy));
    check_field("entry_idx",  64'(out_entry_idx),     64'(e.idx));
    check_field("miss_cnt",   64'(out_miss_cnt),      64'(e.miss));
    check_field("port",       64'(out_port_number),   64'(e.port));
    check_field("buffer",     64'(out_buffer_number), 64'(e.bufn));
    check_field("flow",       64'(out_flow_id),       64'(e.flow));
    check_field("win_start",  out_window_start,       e.ws);
    check_field("win_end",    out_window_end,         e.we);
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.wr = 1'b0; e.busy = 1'b0; e.idx = h_idx; e.miss = h_miss;
    e.port = h_port; e.bufn = h_buf; e.flow = h_flow; e.ws = h_ws; e.we = h_we;
    return e;
  endfunction

  function automatic void mark(input int c, input logic busy, input logic wr);
    if (c < seg_len) begin
      exp_a[c]      = idle_exp();
      exp_a[c].busy = busy;
      exp_a[c].wr   = wr;
    end
  endfunction

  function automatic void clear_held();
    h_port = '0; h_buf = '0; h_flow = '0; h_miss = '0; h_ws = '0; h_we = '0; h_idx = '0;
  endfunction

  // Walks the schedule entry by entry: fetch, wait for ready, wait for the lead
  // window (or expiry), then issue plus guard; a low enable ends the run.
  task automatic build_expect(input int len);
    int n, c, numl, outcome;
    bit run;
    logic [63:0] base, as, ae;
    n = 0;
    base = '0;
    while (n < len) begin
      mark(n, 1'b0, 1'b0);
      if (!(s_en[n] && s_num != 4'd0)) begin
        n++;
        continue;
      end
      base  = s_gt[n];
      numl  = (s_num > 4'd8) ? 8 : int'(s_num);
      h_idx = '0;
      n++;
      run = 1'b1;
      while (run && n < len) begin
        c = n;
        mark(c, 1'b1, 1'b0);
        if (!s_en[c]) begin n = c + 1; run = 1'b0; continue; end
        as = base + m_start[h_idx];
        ae = base + m_end[h_idx];
        c++;
        while (c < len && s_en[c] && !s_rdy[c]) begin mark(c, 1'b1, 1'b0); c++; end
        if (c >= len) begin n = len; continue; end
        mark(c, 1'b1, 1'b0);
        if (!s_en[c]) begin n = c + 1; run = 1'b0; continue; end
        c++;
        outcome = 0;
        while (c < len && outcome == 0) begin
          mark(c, 1'b1, 1'b0);
          if (!s_en[c]) outcome = 3;
          else if (s_gt[c] > ae) outcome = 1;
          else if (s_gt[c] + 64'(LEAD) >= as) outcome = 2;
          else c++;
        end
        if (c >= len) begin n = len; continue; end
        if (outcome == 3) begin n = c + 1; run = 1'b0; continue; end
        if (outcome == 1) begin
          if (h_miss != 16'hFFFF) h_miss++;
          if (int'(h_idx) + 1 < numl) h_idx++;
          else begin h_idx = '0; base = base + s_period; end
          n = c + 1;
          continue;
        end
        c++;
        h_port = m_port[h_idx]; h_buf = m_buf[h_idx]; h_flow = m_flow[h_idx];
        h_ws = as; h_we = ae;
        mark(c, 1'b1, 1'b1);
        if (!s_en[c]) begin n = c + 1; run = 1'b0; continue; end
        if (int'(h_idx) + 1 < numl) h_idx++;
        else begin h_idx = '0; base = base + s_period; end
        c++;
        mark(c, 1'b1, 1'b0);
        if (!s_en[c]) begin n = c + 1; run = 1'b0; continue; end
        n = c + 1;
      end
    end
  endtask

  function automatic int nth_strobe(input int k);
    int seen = 0;
    for (int i = 0; i < seg_len; i++) begin
      if (exp_a[i].wr) begin
        seen++;
        if (seen == k) return i;
      end
    end
    return -1;
  endfunction

  function automatic int strobe_count();
    int cnt = 0;
    for (int i = 0; i < seg_len; i++) if (exp_a[i].wr) cnt++;
    return cnt;
  endfunction

  task automatic fill_linear(input int len, input logic [63:0] g0, input logic [63:0] step,
                             input int rdy_from, input int en_until);
    for (int i = 0; i < MAXC; i++) begin
      s_gt[i]  = g0 + step * 64'(i);
      s_rdy[i] = (i >= rdy_from);
      s_en[i]  = (i < en_until) && (i < len - 1);
    end
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < MAXC; i++) begin
      s_gt[i]  = (i == 0) ? 64'($urandom_range(0, 2000)) : s_gt[i-1] + 64'($urandom_range(0, 30));
      s_rdy[i] = ($urandom_range(0, 3) != 0);
      s_en[i]  = ($urandom_range(0, 199) != 0) && (i < len - 1);
    end
  endtask

  task automatic prepare(input int len, input int wcyc, input logic [2:0] waddr);
    seg_len = len;
    build_expect(len);
    if (wcyc >= 0 && wcyc < len && !exp_a[wcyc].busy) begin
      m_port[waddr] = w_port; m_buf[waddr] = w_buf; m_flow[waddr] = w_flow;
      m_start[waddr] = w_start; m_end[waddr] = w_end;
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] p, input logic [15:0] b,
                           input logic [63:0] st, input logic [63:0] en, input logic [15:0] f);
    @(posedge clk); #1;
    rst_n = 1'b1; cfg_enable = 1'b0; cfg_wr = 1'b1; cfg_addr = a;
    cfg_port = p; cfg_buffer = b; cfg_start = st; cfg_end = en; cfg_flow = f;
    @(negedge clk);
    cyc = -1;
    check_output(idle_exp());
    m_port[a] = p; m_buf[a] = b; m_flow[a] = f; m_start[a] = st; m_end[a] = en;
  endtask

  task automatic apply_stimulus(input int len, input int wcyc, input logic [2:0] waddr, input int rcyc);
    for (int n = 0; n < len; n++) begin
      @(posedge clk); #1;
      in_global_time = s_gt[n];
      in_table_rdy   = s_rdy[n];
      cfg_enable     = s_en[n];
      cfg_num        = s_num;
      cfg_period     = s_period;
      rst_n          = (n == rcyc) ? 1'b0 : 1'b1;
      cfg_wr         = (n == wcyc);
      if (n == wcyc) begin
        cfg_addr = waddr; cfg_port = w_port; cfg_buffer = w_buf;
        cfg_start = w_start; cfg_end = w_end; cfg_flow = w_flow;
      end
      @(negedge clk);
      cyc = n;
      check_output(exp_a[n]);
    end
    cfg_wr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_enable = 1'b0; in_table_rdy = 1'b0;
    cfg_addr = '0; cfg_port = '0; cfg_buffer = '0; cfg_flow = '0;
    cfg_start = '0; cfg_end = '0; cfg_num = '0; cfg_period = '0; in_global_time = '0;
    w_port = '0; w_buf = '0; w_flow = '0; w_start = '0; w_end = '0;
    clear_held();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output(idle_exp());

    for (int i = 0; i < 8; i++)
      cfg_write(3'(i), 16'(100 + i), 16'(200 + i), 64'(500 * i), 64'(500 * i + 300), 16'(300 + i));

    // Basic issue: decision at global time 800, strobe on cycle 81.
    cfg_write(3'd0, 16'd2, 16'd1, 64'd1000, 64'd1500, 16'd7);
    s_num = 4'd1; s_period = 64'd1_000_000;
    fill_linear(100, 64'd0, 64'd10, 0, MAXC);
    prepare(100, -1, 3'd0);
    check_field("pin_basic_cycle", 64'(nth_strobe(1)), 64'd81);
    check_field("pin_basic_start", exp_a[81].ws, 64'd1000);
    check_field("pin_basic_end",   exp_a[81].we, 64'd1500);
    check_field("pin_basic_port",  64'(exp_a[81].port), 64'd2);
    apply_stimulus(100, -1, 3'd0, -1);

    // Period wrap: the third strobe is entry 0 of the second period.
    cfg_write(3'd0, 16'd3, 16'd4, 64'd1000, 64'd1500, 16'd8);
    cfg_write(3'd1, 16'd5, 16'd6, 64'd2000, 64'd2600, 16'd9);
    s_num = 4'd2; s_period = 64'd5000;
    fill_linear(160, 64'd0, 64'd50, 0, MAXC);
    prepare(160, -1, 3'd0);
    check_field("pin_wrap_cycle", 64'(nth_strobe(3)), 64'd117);
    check_field("pin_wrap_start", exp_a[117].ws, 64'd6000);
    check_field("pin_wrap_end",   exp_a[117].we, 64'd6500);
    apply_stimulus(160, -1, 3'd0, -1);

    // Miss: entry 0 already expired when first evaluated.
    cfg_write(3'd0, 16'h0A, 16'h0B, 64'd50, 64'd100, 16'h0C);
    cfg_write(3'd1, 16'h1A, 16'h1B, 64'd3000, 64'd4000, 16'h1C);
    s_num = 4'd2; s_period = 64'd1_000_000;
    fill_linear(20, 64'd300, 64'd100, 0, MAXC);
    prepare(20, -1, 3'd0);
    check_field("pin_miss_cnt",  64'(exp_a[4].miss), 64'd1);
    check_field("pin_miss_idx",  64'(exp_a[4].idx), 64'd1);
    check_field("pin_miss_none", 64'(strobe_count()), 64'd0);
    apply_stimulus(20, -1, 3'd0, -1);

    // Backpressure: ready rises on cycle 30, strobe on 32, guard on 33.
    cfg_write(3'd0, 16'h2A, 16'h2B, 64'd1000, 64'd3000, 16'h2C);
    s_num = 4'd1;
    fill_linear(60, 64'd0, 64'd50, 30, MAXC);
    prepare(60, -1, 3'd0);
    check_field("pin_bp_cycle", 64'(nth_strobe(1)), 64'd32);
    check_field("pin_bp_guard", 64'(exp_a[33].wr), 64'd0);
    check_field("pin_bp_count", 64'(strobe_count()), 64'd1);
    apply_stimulus(60, -1, 3'd0, -1);

    // Disable in the lead wait, with a table write attempted while busy.
    cfg_write(3'd0, 16'h11, 16'h22, 64'd100000, 64'd200000, 16'h33);
    fill_linear(20, 64'd0, 64'd10, 0, 10);
    w_port = 16'hDEAD; w_buf = 16'hBEEF; w_start = 64'd5; w_end = 64'd6; w_flow = 16'hF00D;
    prepare(20, 6, 3'd0);
    check_field("pin_dis_busy", 64'(exp_a[10].busy), 64'd1);
    check_field("pin_dis_idle", 64'(exp_a[11].busy), 64'd0);
    check_field("pin_dis_none", 64'(strobe_count()), 64'd0);
    apply_stimulus(20, 6, 3'd0, -1);

    // Reset while the strobe is high; the entry must be the original one.
    fill_linear(52, 64'd0, 64'd2000, 0, MAXC);
    prepare(52, -1, 3'd0);
    check_field("pin_rst_strobe", 64'(exp_a[51].wr), 64'd1);
    check_field("pin_rst_port",   64'(exp_a[51].port), 64'h11);
    apply_stimulus(52, -1, 3'd0, 51);
    @(posedge clk); #1;
    rst_n = 1'b1; cfg_enable = 1'b0;
    clear_held();
    @(negedge clk);
    cyc = 52;
    check_output(idle_exp());

    // Re-enable after reset reissues the retained entry 0.
    fill_linear(60, 64'd0, 64'd2000, 0, MAXC);
    prepare(60, -1, 3'd0);
    check_field("pin_re_cycle", 64'(nth_strobe(1)), 64'd51);
    check_field("pin_re_start", exp_a[51].ws, 64'd100000);
    apply_stimulus(60, -1, 3'd0, -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) begin
        logic [63:0] st;
        st = 64'($urandom_range(0, 3000));
        cfg_write(3'(i), 16'($urandom), 16'($urandom), st,
                  st + 64'($urandom_range(0, 1500)), 16'($urandom));
      end
      s_num    = 4'($urandom_range(0, 15));
      s_period = 64'($urandom_range(3000, 6000));
      fill_random(600);
      prepare(600, -1, 3'd0);
      apply_stimulus(600, -1, 3'd0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/schedule_table_sequencer.md
SCHEDULE_TABLE_SEQUENCER -- requirements
Module: schedule_table_sequencer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset; parameters are listed one per line as name, default, meaning:
- DEPTH, 8: number of schedule table entries.
- LEAD, 200: time units before the absolute window start at which an entry may be issued.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: synchronous active-low reset.
- cfg_wr, in, 1: write one table entry.
- cfg_addr, in, 3: entry index to write.
- cfg_port, in, 16: egress port number.
- cfg_buffer, in, 16: buffer number.
- cfg_start, in, 64: window start offset within the period.
- cfg_end, in, 64: window end offset within the period.
- cfg_flow, in, 16: flow id.
- cfg_num, in, 4: count of valid entries (0..8).
- cfg_period, in, 64: schedule period.
- cfg_enable, in, 1: run the schedule.
- in_global_time, in, 64: global time.
- in_table_rdy, in, 1: window checker ready for a table entry.
- out_table_wr, out, 1: one-cycle entry-write strobe.
- out_port_number, out, 16: entry port.
- out_buffer_number, out, 16: entry buffer.
- out_window_start, out, 64: absolute window start.
- out_window_end, out, 64: absolute window end.
- out_flow_id, out, 16: entry flow id.
- out_busy, out, 1: high when state is not IDLE.
- out_entry_idx, out, 3: current entry index.
- out_miss_cnt, out, 16: count of skipped (expired) entries.

Function
REQ-003 The FSM SHALL have the states IDLE, FETCH, WAIT_RDY, WAIT_LEAD, ISSUE and GUARD.
REQ-004 In IDLE with cfg_enable=1 and cfg_num!=0, the module SHALL latch base<=in_global_time and cfg_num, set idx<=0, and go to FETCH; if cfg_num=0 it SHALL stay in IDLE.
REQ-005 FETCH SHALL compute abs_start=base+start[idx] and abs_end=base+end[idx] as 64-bit values with modulo-2^64 wrap, then go to WAIT_RDY.
REQ-006 WAIT_RDY SHALL go to WAIT_LEAD when in_table_rdy=1.
REQ-007 WAIT_LEAD SHALL handle entry timing as follows:
- If in_global_time > abs_end, the entry is expired: increment out_miss_cnt (saturating at 0xFFFF), advance idx, and go to FETCH.
- Else if in_global_time + LEAD >= abs_start, go to ISSUE.
- Expiry SHALL take priority over issue when both conditions hold.
REQ-008 ISSUE SHALL drive out_table_wr=1 for exactly one cycle, with all out_* entry fields valid in that same cycle and held until the next ISSUE; it SHALL then advance idx and go to GUARD.
REQ-009 GUARD SHALL last exactly one cycle, ignore in_table_rdy, and go to FETCH; this absorbs the checker's one-cycle ready deassertion latency.
REQ-010 Advancing idx SHALL work as follows:
- If idx+1 < latched num, idx<=idx+1.
- Otherwise idx<=0 and base<=base+cfg_period (modulo 2^64).
REQ-011 cfg_enable=0 SHALL force IDLE on the next edge from any state, with no further out_table_wr; an ISSUE strobe already being driven in that cycle SHALL complete.
REQ-012 When out_busy=0, cfg_wr SHALL write the entry at cfg_addr on the clock edge. When out_busy=1, cfg_wr SHALL be ignored.
REQ-013 cfg_num values greater than DEPTH SHALL be clamped to DEPTH when latched.
REQ-014 Table contents SHALL be held in registers. No output SHALL depend combinationally on any input.
REQ-015 Minimum spacing between consecutive out_table_wr pulses SHALL be 5 cycles (ISSUE, GUARD, FETCH, WAIT_RDY, WAIT_LEAD).

Reset
REQ-016 With rst_n=0 at a rising edge, the module SHALL enter IDLE and clear the following: out_table_wr, all out_* entry fields, out_busy, out_entry_idx, out_miss_cnt, base and idx.
REQ-017 Reset SHALL NOT clear table contents.
REQ-018 Reset asserted mid-ISSUE SHALL drop out_table_wr on that same edge.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Basic issue: one entry {port 2, buf 1, start 1000, end 1500}, num=1, enable at time 0, rdy=1 -> out_table_wr when global_time=800, out_window_start=1000, out_window_end=1500.
- Period wrap: two entries, period 5000, rdy=1 -> third strobe carries window_start = 5000 + start[0].
- Miss: entry end=100, enable at global_time=300 -> no strobe, out_miss_cnt=1, idx advances.
- Backpressure: rdy=0 past abs_start while before abs_end -> strobe only after rdy rises; no strobe during GUARD even when rdy=1.
- Disable mid-run: cfg_enable drops in WAIT_LEAD -> IDLE next cycle, out_busy=0, no strobe; cfg_wr while busy leaves table unchanged.
- Reset mid-ISSUE: rst_n=0 -> out_table_wr=0 and out_miss_cnt=0 on that edge; table entries are retained, so re-enabling reissues entry 0 unchanged.
